// File: rtl/fetch_target_queue_pkg.sv
// Shared frontend definitions for the fetch target queue: default sizing,
// the queue entry layout and the pointer width derived from the depth.
package fetch_target_queue_pkg;

  localparam int FTQ_DEPTH     = 4;
  localparam int FTQ_PC_W      = 31;
  localparam int FTQ_FID_W     = 5;
  localparam int FTQ_OFFS_W    = 3;
  localparam int FTQ_WFI_DELAY = 1024;
  localparam int FTQ_PTR_W     = $clog2(FTQ_DEPTH);

  typedef struct packed {
    logic [FTQ_PC_W-1:0]   pc;
    logic [FTQ_OFFS_W-1:0] lastOffs;
    logic [FTQ_FID_W-1:0]  fetchID;
    logic                  intr;
  } FTQEntry_t;

endpackage

// File: rtl/fetch_target_queue_if.sv
// Bundle of everything the fetch target queue exchanges with the predictor,
// the icache and the backend. The master side is the surrounding frontend,
// the slave side is the queue itself.
interface fetch_target_queue_if
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH = FTQ_DEPTH
);

  logic                    IN_en;
  logic                    IN_interruptPending;
  logic                    IN_mispr;
  logic [FTQ_FID_W-1:0]    IN_misprFetchID;
  logic                    IN_misprWfi;
  logic [FTQ_FID_W-1:0]    IN_comFetchID;
  logic                    IN_bpValid;
  logic [FTQ_PC_W-1:0]     IN_bpPC;
  logic [FTQ_OFFS_W-1:0]   IN_bpLastOffs;
  logic                    OUT_bpReady;
  logic [FTQ_FID_W-1:0]    OUT_bpFetchID;
  logic                    OUT_icValid;
  logic                    IN_icReady;
  logic [FTQ_PC_W-1:0]     OUT_icPC;
  logic [FTQ_OFFS_W-1:0]   OUT_icLastOffs;
  logic [FTQ_FID_W-1:0]    OUT_icFetchID;
  logic                    OUT_icIntr;
  logic                    OUT_wfi;
  logic [$clog2(DEPTH):0]  OUT_count;

  modport master (
    output IN_en, IN_interruptPending, IN_mispr, IN_misprFetchID, IN_misprWfi,
           IN_comFetchID, IN_bpValid, IN_bpPC, IN_bpLastOffs, IN_icReady,
    input  OUT_bpReady, OUT_bpFetchID, OUT_icValid, OUT_icPC, OUT_icLastOffs,
           OUT_icFetchID, OUT_icIntr, OUT_wfi, OUT_count
  );

  modport slave (
    input  IN_en, IN_interruptPending, IN_mispr, IN_misprFetchID, IN_misprWfi,
           IN_comFetchID, IN_bpValid, IN_bpPC, IN_bpLastOffs, IN_icReady,
    output OUT_bpReady, OUT_bpFetchID, OUT_icValid, OUT_icPC, OUT_icLastOffs,
           OUT_icFetchID, OUT_icIntr, OUT_wfi, OUT_count
  );

endinterface

// File: rtl/fetch_target_queue_wfi_timer.sv
// Frontend quiesce timer. A redirect may request WFI; the quiesce then lasts
// at most WFI_DELAY cycles and ends early as soon as an interrupt is pending.
module ftq_wfi_timer #(
  parameter int WFI_DELAY = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic loadWfi,
  input  logic wake,
  output logic wfi
);

  localparam int CNT_W = $clog2(WFI_DELAY);

  logic [CNT_W-1:0] counter;

  // Load on redirect, then count down; leaving quiesce happens when the
  // countdown would go below zero or when an interrupt wakes the core.
  always_ff @(posedge clk) begin
    if (rst) begin
      wfi     <= 1'b0;
      counter <= '0;
    end else if (load) begin
      wfi     <= loadWfi;
      counter <= loadWfi ? CNT_W'(WFI_DELAY - 1) : '0;
    end else if (wfi) begin
      if (wake) begin
        wfi <= 1'b0;
      end else if (counter == '0) begin
        wfi <= 1'b0;
      end else begin
        counter <= counter - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fetch_target_queue.sv
// Fetch target queue: decouples the branch predictor from the icache,
// hands out sequential fetch IDs bounded by the commit point, owns WFI
// quiesce and single-shot interrupt-marker injection.
// Optional build macro FTQ_BYPASS_EN: an empty queue forwards an accepted
// block straight to the icache in the same cycle when the icache is ready.
module fetch_target_queue
  import fetch_target_queue_pkg::*;
#(
  parameter int DEPTH     = FTQ_DEPTH,
  parameter int WFI_DELAY = FTQ_WFI_DELAY
) (
  input logic clk,
  input logic rst,
  fetch_target_queue_if.slave bus
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  FTQEntry_t          mem [DEPTH];
  logic [PTR_W-1:0]   headPtr;
  logic [PTR_W-1:0]   tailPtr;
  logic [CNT_W-1:0]   count;
  logic [FTQ_FID_W-1:0] nextFID;
  logic [FTQ_FID_W-1:0] nextFIDInc;
  logic               issuedIntr;
  logic               wfi;

  logic      full;
  logic      empty;
  logic      limitHit;
  logic      bpReady;
  logic      accept;
  logic      storedValid;
  logic      bypassFire;
  logic      doEnq;
  logic      doDeq;
  FTQEntry_t newEntry;
  FTQEntry_t headEntry;

  assign full        = (count == CNT_W'(DEPTH));
  assign empty       = (count == '0);
  assign nextFIDInc  = nextFID + FTQ_FID_W'(1);
  assign limitHit    = (nextFIDInc == bus.IN_comFetchID);
  assign bpReady     = !rst && bus.IN_en && !wfi && !issuedIntr && !full &&
                       !limitHit && !bus.IN_mispr;
  assign accept      = bus.IN_bpValid && bpReady;
  assign storedValid = !rst && !empty;

`ifdef FTQ_BYPASS_EN
  assign bypassFire  = empty && accept && bus.IN_icReady;
`else
  assign bypassFire  = 1'b0;
`endif

  assign doEnq     = accept && !bypassFire;
  assign doDeq     = storedValid && bus.IN_icReady && !bus.IN_mispr;
  assign headEntry = mem[headPtr];

  assign newEntry.pc       = bus.IN_bpPC;
  assign newEntry.lastOffs = bus.IN_bpLastOffs;
  assign newEntry.fetchID  = nextFID;
  assign newEntry.intr     = bus.IN_interruptPending;

  // Quiesce timer is reloaded by every redirect and woken by interrupts.
  ftq_wfi_timer #(
    .WFI_DELAY (WFI_DELAY)
  ) wfiTimer (
    .clk     (clk),
    .rst     (rst),
    .load    (bus.IN_mispr),
    .loadWfi (bus.IN_misprWfi),
    .wake    (bus.IN_interruptPending),
    .wfi     (wfi)
  );

  // Entry storage; only written on a real enqueue, never needs clearing.
  always_ff @(posedge clk) begin
    if (doEnq) begin
      mem[tailPtr] <= newEntry;
    end
  end

  // Queue bookkeeping and fetch-ID allocation; a redirect flushes everything
  // and restarts allocation right after the redirecting block.
  always_ff @(posedge clk) begin
    if (rst) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      count      <= '0;
      nextFID    <= '0;
      issuedIntr <= 1'b0;
    end else if (bus.IN_mispr) begin
      headPtr    <= '0;
      tailPtr    <= '0;
      count      <= '0;
      nextFID    <= bus.IN_misprFetchID + FTQ_FID_W'(1);
      issuedIntr <= 1'b0;
    end else begin
      if (accept) begin
        nextFID <= nextFIDInc;
        if (bus.IN_interruptPending) begin
          issuedIntr <= 1'b1;
        end
      end
      if (doEnq) begin
        tailPtr <= tailPtr + PTR_W'(1);
      end
      if (doDeq) begin
        headPtr <= headPtr + PTR_W'(1);
      end
      if (doEnq && !doDeq) begin
        count <= count + CNT_W'(1);
      end else if (!doEnq && doDeq) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Icache-facing view: stored head first, bypassed block when the queue is
  // empty, zeros otherwise so nothing stale leaks out.
  always_comb begin
    bus.OUT_icValid    = 1'b0;
    bus.OUT_icPC       = '0;
    bus.OUT_icLastOffs = '0;
    bus.OUT_icFetchID  = '0;
    bus.OUT_icIntr     = 1'b0;
    if (storedValid) begin
      bus.OUT_icValid    = 1'b1;
      bus.OUT_icPC       = headEntry.pc;
      bus.OUT_icLastOffs = headEntry.lastOffs;
      bus.OUT_icFetchID  = headEntry.fetchID;
      bus.OUT_icIntr     = headEntry.intr;
    end else if (bypassFire) begin
      bus.OUT_icValid    = 1'b1;
      bus.OUT_icPC       = newEntry.pc;
      bus.OUT_icLastOffs = newEntry.lastOffs;
      bus.OUT_icFetchID  = newEntry.fetchID;
      bus.OUT_icIntr     = newEntry.intr;
    end
  end

  assign bus.OUT_bpReady   = bpReady;
  assign bus.OUT_bpFetchID = rst ? '0 : nextFID;
  assign bus.OUT_wfi       = !rst && wfi;
  assign bus.OUT_count     = rst ? '0 : count;

endmodule

// File: doc/fetch_target_queue.md
Name: fetch_target_queue

Overview:
- Decoupling queue between branch predictor and instruction cache; replaces the single-cycle predictor-to-cache coupling of the current fetch unit.
- Buffers up to DEPTH predicted fetch blocks, assigns sequential fetch IDs and enforces the in-flight fetch-ID limit against commit.
- Owns frontend quiesce (WFI) and single-shot interrupt-marker injection.
- On redirect it flushes all entries and restarts fetch-ID allocation.

Parameters:
- DEPTH, 4, queue entries; power of two, 2..16.
- PC_W, 31, halfword-granular PC width.
- FID_W, 5, fetch-ID width; IDs wrap mod 2^FID_W.
- OFFS_W, 3, last-valid-offset width within a fetch block.
- WFI_DELAY, 1024, maximum WFI quiesce cycles; power of two, >= 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- IN_en  in  1  global frontend enable
- IN_interruptPending  in  1  interrupt awaiting injection
- IN_mispr  in  1  redirect (backend or decode)
- IN_misprFetchID  in  FID_W  fetch ID of the redirecting block
- IN_misprWfi  in  1  redirect also requests WFI quiesce
- IN_comFetchID  in  FID_W  oldest uncommitted fetch ID
- IN_bpValid  in  1  predictor presents block
- IN_bpPC  in  PC_W  block start PC
- IN_bpLastOffs  in  OFFS_W  last valid offset
- OUT_bpReady  out  1  queue accepts block
- OUT_bpFetchID  out  FID_W  ID assigned to the presented block
- OUT_icValid  out  1  head entry valid
- IN_icReady  in  1  icache accepts head
- OUT_icPC  out  PC_W  head PC
- OUT_icLastOffs  out  OFFS_W  head last offset
- OUT_icFetchID  out  FID_W  head fetch ID
- OUT_icIntr  out  1  head is the interrupt marker
- OUT_wfi  out  1  quiesce active
- OUT_count  out  $clog2(DEPTH)+1  occupancy

Behaviour:
- Reset: queue empty; allocation ID nextFID=0; wfi=0; issuedIntr=0.
- Outputs during reset: OUT_bpReady=0, OUT_icValid=0, OUT_wfi=0, OUT_count=0, all data outputs 0.
- Allocation limit: limitHit = (nextFID+1 mod 2^FID_W) == IN_comFetchID.
- Ready condition: OUT_bpReady = IN_en && !wfi && !issuedIntr && !full && !limitHit && !IN_mispr.
- OUT_bpFetchID = nextFID.
- Enqueue (IN_bpValid && OUT_bpReady): write {PC, lastOffs, nextFID, intr=IN_interruptPending}; nextFID += 1 (wraps).
- If intr=1 on enqueue: issuedIntr <= 1; no further enqueues until the next IN_mispr.
- Dequeue (OUT_icValid && IN_icReady): head pointer advances.
- Head visibility latency: 1 cycle (enqueue at cycle N, head visible at N+1).
- Simultaneous enqueue and dequeue when full: not possible, because ready is gated by full, not full-minus-dequeue.
- Simultaneous enqueue and dequeue at any other occupancy: count unchanged.
- Pointers are $clog2(DEPTH) bits and wrap naturally; full/empty are distinguished by OUT_count.
- IN_mispr has priority over everything in the same cycle:
  - queue empty, enqueue and dequeue suppressed;
  - nextFID <= IN_misprFetchID+1;
  - issuedIntr <= 0;
  - wfi <= IN_misprWfi; if set, counter <= WFI_DELAY-1.
- WFI: while wfi, counter decrements each cycle; wfi clears when IN_interruptPending=1 or the decrement underflows below 0. Maximum quiesce is WFI_DELAY cycles.
- IN_en=0 blocks enqueue only; queued entries continue to drain.
- Reset mid-operation discards all entries and state; no output is held over.

Optional Feature:
- Macro: FTQ_BYPASS_EN.
- Defined: when the queue is empty, IN_bpValid && OUT_bpReady && IN_icReady passes the block straight to OUT_ic* in the same cycle. Latency 0; no entry is written and the count is unchanged. The interrupt marker can also bypass.
- Undefined: strict 1-cycle latency; OUT_ic* are driven only from storage.

Decomposition:
- Shared frontend package gets:
  - typedef FTQEntry_t {pc, lastOffs, fetchID, intr};
  - localparam FTQ_PTR_W.
- Sub-module: ftq_wfi_timer (counter, load/decrement/underflow, interrupt wake; outputs wfi).

Test Plan:
- Fill/drain: DEPTH=4, IN_icReady=0, enqueue 4 blocks at PC 0x100, 0x108, 0x110, 0x118 -> IDs 0..3, OUT_bpReady=0 at count 4; release IN_icReady -> heads emerge in order, 1 per cycle.
- ID limit: IN_comFetchID=3, nextFID=2 -> OUT_bpReady=0; raise IN_comFetchID to 4 -> block accepted with ID 2.
- Flush: 3 entries queued, IN_mispr with misprFetchID=7 together with bpValid and icReady -> next cycle count=0, OUT_icValid=0; next enqueue gets ID 8.
- Interrupt: IN_interruptPending=1 on enqueue -> entry has OUT_icIntr=1, OUT_bpReady stays 0 until IN_mispr; after IN_mispr, enqueue resumes.
- WFI: IN_mispr with IN_misprWfi=1, WFI_DELAY=8 -> OUT_wfi high for exactly 8 cycles; rerun with IN_interruptPending at cycle 3 -> OUT_wfi clears next cycle.
- Bypass (FTQ_BYPASS_EN): empty queue, bpValid, icReady at cycle N -> OUT_icValid in cycle N, count stays 0; without the macro -> OUT_icValid in cycle N+1.
